// File: rtl/uart_sram_tx_interface_if.sv
// Bus bundle between the SRAM-to-UART transmit block and its surroundings.
// The transmit block is the master of the SRAM read port and owns the UART pin.
interface uart_sram_tx_interface_if;
    logic        Start;
    logic [17:0] Base_address;
    logic [17:0] Word_count;
    logic [15:0] SRAM_read_data;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic        UART_TX_O;
    logic        Busy;
    logic        Done;

    modport master (
        input  Start, Base_address, Word_count, SRAM_read_data,
        output SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
    );

    modport slave (
        output Start, Base_address, Word_count, SRAM_read_data,
        input  SRAM_address, SRAM_we_n, UART_TX_O, Busy, Done
    );
endinterface

// File: rtl/uart_sram_tx_interface.sv
// Reads a block of 16-bit SRAM words and sends them over UART (8N1, high byte first).
// Optional macro TXI_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_sram_tx_interface #(
    parameter int CLKS_PER_BIT      = 434,
    parameter int SRAM_READ_LATENCY = 2
) (
    input logic CLOCK_50_I,
    input logic resetn,
    uart_sram_tx_interface_if.master bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PF_W   = $clog2(SRAM_READ_LATENCY + 2);
`ifdef TXI_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd10;
`else
    localparam logic [3:0] LAST_BIT = 4'd9;
`endif
    localparam logic [BAUD_W-1:0] BAUD_MAX   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] FETCH_WAIT = BAUD_W'(SRAM_READ_LATENCY);
    localparam logic [PF_W-1:0]   PF_START   = PF_W'(SRAM_READ_LATENCY + 1);

    typedef enum logic [2:0] {
        S_TXI_IDLE,
        S_TXI_FETCH,
        S_TXI_SEND_HI,
        S_TXI_SEND_LO,
        S_TXI_DONE
    } state_t;

    state_t            state, state_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_idx;
    logic [17:0]       remaining;
    logic [17:0]       sram_addr;
    logic [15:0]       word_buf;
    logic [15:0]       prefetch_buf;
    logic [PF_W-1:0]   pf_wait;
    logic              tx;
    logic              busy;
    logic              bit_end;
    logic              frame_end;
    logic              more_words;
    logic              first_lo_cycle;
    logic [7:0]        cur_byte;

    // Line level for frame position idx: start, data LSB first, optional parity, stop.
    function automatic logic bit_value(input logic [3:0] idx, input logic [7:0] data);
        logic b;
        b = 1'b1;
        if (idx == 4'd0)
            b = 1'b0;
        else if (idx <= 4'd8)
            b = data[3'(idx - 4'd1)];
`ifdef TXI_PARITY_EN
        else if (idx == 4'd9)
            b = ^data;
`endif
        return b;
    endfunction

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn)
            state <= S_TXI_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        cur_byte       = (state == S_TXI_SEND_LO) ? word_buf[7:0] : word_buf[15:8];
        bit_end        = (baud_cnt == BAUD_MAX);
        frame_end      = bit_end && (bit_idx == LAST_BIT);
        more_words     = (remaining != 18'd1);
        first_lo_cycle = (state == S_TXI_SEND_LO) && (baud_cnt == '0) && (bit_idx == 4'd0);
        case (state)
            S_TXI_IDLE:
                if (bus.Start)
                    state_next = (bus.Word_count == 18'd0) ? S_TXI_DONE : S_TXI_FETCH;
            S_TXI_FETCH:
                if (baud_cnt == FETCH_WAIT)
                    state_next = S_TXI_SEND_HI;
            S_TXI_SEND_HI:
                if (frame_end)
                    state_next = S_TXI_SEND_LO;
            S_TXI_SEND_LO:
                if (frame_end)
                    state_next = more_words ? S_TXI_SEND_HI : S_TXI_DONE;
            S_TXI_DONE:
                state_next = S_TXI_IDLE;
            default:
                state_next = S_TXI_IDLE;
        endcase
    end

    // The next word is prefetched while the low byte is on the line so frames stay gapless.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            baud_cnt     <= '0;
            bit_idx      <= '0;
            remaining    <= '0;
            sram_addr    <= '0;
            word_buf     <= '0;
            prefetch_buf <= '0;
            pf_wait      <= '0;
            tx           <= 1'b1;
            busy         <= 1'b0;
        end else begin
            if (pf_wait != '0) begin
                pf_wait <= pf_wait - 1'b1;
                if (pf_wait == PF_W'(1))
                    prefetch_buf <= bus.SRAM_read_data;
            end
            case (state)
                S_TXI_IDLE: begin
                    if (bus.Start && (bus.Word_count != 18'd0)) begin
                        remaining <= bus.Word_count;
                        sram_addr <= bus.Base_address;
                        busy      <= 1'b1;
                        baud_cnt  <= '0;
                    end
                end
                S_TXI_FETCH: begin
                    if (baud_cnt == FETCH_WAIT) begin
                        word_buf <= bus.SRAM_read_data;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_TXI_SEND_HI, S_TXI_SEND_LO: begin
                    if (first_lo_cycle && more_words) begin
                        sram_addr <= sram_addr + 18'd1;
                        pf_wait   <= PF_START;
                    end
                    if (!bit_end) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (!frame_end) begin
                            bit_idx <= bit_idx + 4'd1;
                            tx      <= bit_value(bit_idx + 4'd1, cur_byte);
                        end else begin
                            bit_idx <= '0;
                            if (state == S_TXI_SEND_HI) begin
                                tx <= 1'b0;
                            end else begin
                                remaining <= remaining - 18'd1;
                                if (more_words) begin
                                    word_buf <= prefetch_buf;
                                    tx       <= 1'b0;
                                end else begin
                                    tx <= 1'b1;
                                end
                            end
                        end
                    end
                end
                S_TXI_DONE: begin
                    busy <= 1'b0;
                    tx   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.SRAM_address = sram_addr;
    assign bus.SRAM_we_n    = 1'b1;
    assign bus.UART_TX_O    = tx;
    assign bus.Busy         = busy;
    assign bus.Done         = (state == S_TXI_DONE);
endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Randomized and directed bench for uart_sram_tx_interface against a queue-based line model.
// Every cycle the DUT pins are compared with the model; directed tests pin the model itself.
module tb_uart_sram_tx_interface;
    localparam int CLKS = 434;
    localparam int LAT  = 2;
`ifdef TXI_PARITY_EN
    localparam int FB = 11;
    localparam int ONE_WORD_CYCLES = 9548;
    localparam int TWO_WORD_CYCLES = 19096;
`else
    localparam int FB = 10;
    localparam int ONE_WORD_CYCLES = 8680;
    localparam int TWO_WORD_CYCLES = 17360;
`endif
    localparam int FRAME = FB * CLKS;
    localparam int FIRST_BIT_DELAY = LAT + 1;

    logic clock_50 = 1'b0;
    logic resetn;

    uart_sram_tx_interface_if bus();

    uart_sram_tx_interface #(
        .CLKS_PER_BIT(CLKS),
        .SRAM_READ_LATENCY(LAT)
    ) dut (
        .CLOCK_50_I(clock_50),
        .resetn(resetn),
        .bus(bus)
    );

    always #10 clock_50 = ~clock_50;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_pulses = 0;

    logic [15:0] mem [int];
    logic [15:0] rd_pipe;

    bit          exp_q [$];
    bit          m_active = 1'b0;
    bit          m_zero;
    int          m_n;
    int          m_done_n;
    logic [17:0] m_addr;
    logic [15:0] m_word;

    bit e_tx, e_busy, e_done;
    int e_idx;

`ifdef TXI_PARITY_EN
    bit seq_t1 [22] = '{0,0,1,0,1,0,0,1,0,1,1, 0,0,0,1,1,1,1,0,0,0,1};
`else
    bit seq_t1 [20] = '{0,0,1,0,1,0,0,1,0,1, 0,0,0,1,1,1,1,0,0,1};
`endif

    int t0, t1, d0, tgt, gap;
    logic [17:0] r_base, r_count;

    always @(posedge clock_50) cyc++;

    always @(negedge clock_50)
        if (bus.Done === 1'b1)
            done_pulses++;

    function automatic logic [15:0] mem_read(input logic [17:0] a);
        if (mem.exists(int'(a)))
            return mem[int'(a)];
        return 16'h0000;
    endfunction

    always @(posedge clock_50) begin
        rd_pipe <= mem_read(bus.SRAM_address);
        bus.SRAM_read_data <= rd_pipe;
    end

    function automatic void push_frame(input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            exp_q.push_back(b[i]);
`ifdef TXI_PARITY_EN
        exp_q.push_back(^b);
`endif
        exp_q.push_back(1'b1);
    endfunction

    // Model: on acceptance, build the whole expected bit stream; n counts edges since acceptance.
    always @(posedge clock_50) begin
        if (!resetn) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_n++;
            if (m_n > m_done_n)
                m_active = 1'b0;
        end else if (bus.Start) begin
            m_active = 1'b1;
            m_n = 0;
            m_zero = (bus.Word_count == 18'd0);
            exp_q.delete();
            for (int w = 0; w < int'(bus.Word_count); w++) begin
                m_addr = bus.Base_address + 18'(w);
                m_word = mem_read(m_addr);
                push_frame(m_word[15:8]);
                push_frame(m_word[7:0]);
            end
            m_done_n = m_zero ? 0 : FIRST_BIT_DELAY + exp_q.size() * CLKS;
        end
    end

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
            if (bad >= 200)
                finish_run();
        end
    endtask

    always @(negedge clock_50) begin
        e_tx = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (resetn && m_active) begin
            e_done = (m_n == m_done_n);
            if (!m_zero) begin
                e_busy = 1'b1;
                if (m_n >= FIRST_BIT_DELAY) begin
                    e_idx = (m_n - FIRST_BIT_DELAY) / CLKS;
                    if (e_idx < exp_q.size())
                        e_tx = exp_q[e_idx];
                end
            end
        end
        check_output("model_tx", 32'(bus.UART_TX_O), 32'(e_tx));
        check_output("model_busy", 32'(bus.Busy), 32'(e_busy));
        check_output("model_done", 32'(bus.Done), 32'(e_done));
        check_output("model_we_n", 32'(bus.SRAM_we_n), 32'd1);
    end

    task automatic apply_stimulus(input logic [17:0] base, input logic [17:0] count);
        bus.Base_address = base;
        bus.Word_count = count;
        bus.Start = 1'b1;
        @(negedge clock_50);
        bus.Start = 1'b0;
        bus.Base_address = 18'($urandom);
        bus.Word_count = 18'($urandom);
    endtask

    task automatic wait_tx_low(input int budget, output int when);
        when = -1;
        for (int k = 0; k < budget; k++) begin
            if (bus.UART_TX_O == 1'b0) begin
                when = cyc;
                break;
            end
            @(negedge clock_50);
        end
        check_output("start_bit_seen", 32'(when >= 0), 32'd1);
    endtask

    task automatic wait_done(input int budget, output int when);
        when = -1;
        for (int k = 0; k < budget; k++) begin
            if (bus.Done == 1'b1) begin
                when = cyc;
                break;
            end
            @(negedge clock_50);
        end
        check_output("done_seen", 32'(when >= 0), 32'd1);
    endtask

    initial begin
        #2600000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        bad++;
        finish_run();
    end

    initial begin
        resetn = 1'b0;
        bus.Start = 1'b0;
        bus.Base_address = '0;
        bus.Word_count = '0;
        repeat (4) @(negedge clock_50);
        check_output("reset_addr", 32'(bus.SRAM_address), 32'd0);
        check_output("reset_tx", 32'(bus.UART_TX_O), 32'd1);
        check_output("reset_busy", 32'(bus.Busy), 32'd0);
        check_output("reset_done", 32'(bus.Done), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clock_50);

        mem[146944] = 16'h4A3C;
        d0 = done_pulses;
        apply_stimulus(18'd146944, 18'd1);
        check_output("t1_addr", 32'(bus.SRAM_address), 32'd146944);
        wait_tx_low(20, t0);
        for (int i = 0; i < 2 * FB; i++) begin
            tgt = t0 + i * CLKS + CLKS / 2;
            while (cyc < tgt) @(negedge clock_50);
            check_output($sformatf("t1_bit%0d", i), 32'(bus.UART_TX_O), 32'(seq_t1[i]));
        end
        wait_done(FRAME + 50, t1);
        check_output("t1_duration", 32'(t1 - t0), 32'(ONE_WORD_CYCLES));
        repeat (5) @(negedge clock_50);
        check_output("t1_done_count", 32'(done_pulses - d0), 32'd1);

        mem[0] = 16'h1234;
        mem[1] = 16'hABCD;
        d0 = done_pulses;
        apply_stimulus(18'd0, 18'd2);
        wait_tx_low(20, t0);
        wait_done(2 * 2 * FRAME + 50, t1);
        check_output("t2_duration", 32'(t1 - t0), 32'(TWO_WORD_CYCLES));
        bus.Base_address = 18'd0;
        bus.Word_count = 18'd1;
        bus.Start = 1'b1;
        @(negedge clock_50);
        bus.Start = 1'b0;
        repeat (6) @(negedge clock_50);
        check_output("t2_start_at_done_busy", 32'(bus.Busy), 32'd0);
        check_output("t2_done_count", 32'(done_pulses - d0), 32'd1);

        d0 = done_pulses;
        apply_stimulus(18'd5, 18'd0);
        check_output("t3_done_next", 32'(bus.Done), 32'd1);
        check_output("t3_busy", 32'(bus.Busy), 32'd0);
        repeat (4) @(negedge clock_50);
        check_output("t3_tx_idle", 32'(bus.UART_TX_O), 32'd1);
        check_output("t3_done_count", 32'(done_pulses - d0), 32'd1);

        mem[262143] = 16'hC35A;
        mem[0] = 16'h0F96;
        d0 = done_pulses;
        apply_stimulus(18'h3FFFF, 18'd2);
        check_output("t4_addr_first", 32'(bus.SRAM_address), 32'h3FFFF);
        wait_tx_low(20, t0);
        repeat (FRAME + 100) @(negedge clock_50);
        bus.Base_address = 18'd7;
        bus.Word_count = 18'd1;
        bus.Start = 1'b1;
        @(negedge clock_50);
        bus.Start = 1'b0;
        wait_done(2 * 2 * FRAME + 50, t1);
        repeat (5) @(negedge clock_50);
        check_output("t4_addr_wrapped", 32'(bus.SRAM_address), 32'h00000);
        check_output("t4_done_count", 32'(done_pulses - d0), 32'd1);

        mem[100] = 16'h35F0;
        d0 = done_pulses;
        apply_stimulus(18'd100, 18'd1);
        wait_tx_low(20, t0);
        tgt = t0 + 4 * CLKS + CLKS / 2;
        while (cyc < tgt) @(negedge clock_50);
        check_output("t5_data_bit3", 32'(bus.UART_TX_O), 32'd0);
        @(posedge clock_50);
        #3 resetn = 1'b0;
        #1;
        check_output("t5_reset_tx", 32'(bus.UART_TX_O), 32'd1);
        check_output("t5_reset_busy", 32'(bus.Busy), 32'd0);
        repeat (3) @(negedge clock_50);
        resetn = 1'b1;
        repeat (3) @(negedge clock_50);
        check_output("t5_no_done", 32'(done_pulses - d0), 32'd0);
        check_output("t5_idle_addr", 32'(bus.SRAM_address), 32'd0);
        apply_stimulus(18'd100, 18'd1);
        wait_done(FRAME * 2 + 50, t1);
        repeat (3) @(negedge clock_50);
        check_output("t5_done_after_reset", 32'(done_pulses - d0), 32'd1);

        r_base = 18'($urandom);
        r_count = 18'($urandom_range(1, 2));
        mem[int'(r_base)] = 16'($urandom);
        mem[int'(r_base + 18'd1)] = 16'($urandom);
        gap = $urandom_range(0, 20);
        repeat (gap) @(negedge clock_50);
        d0 = done_pulses;
        apply_stimulus(r_base, r_count);
        check_output("t6_addr", 32'(bus.SRAM_address), 32'(r_base));
        wait_done(2 * 2 * FRAME + 50, t1);
        repeat (5) @(negedge clock_50);
        check_output("t6_done_count", 32'(done_pulses - d0), 32'd1);

        finish_run();
    end
endmodule

// File: doc/uart_sram_tx_interface.md
Name: uart_sram_tx_interface

Overview:
- Reads a block of 16-bit words from external SRAM and serializes them onto the UART transmit pin, high byte first.
- It is the transmit counterpart of the existing UART-to-SRAM receive path: same 8N1 frame, same 115200 baud, same SRAM controller port.
- It sits beside the receive interface under the top-level FSM. The top-level grants it the SRAM port during a dump state and drives UART_TX_O from it.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200, truncated).
- SRAM_READ_LATENCY, 2, cycles from SRAM_address being presented to SRAM_read_data being valid at the SRAM controller.

Ports:
- CLOCK_50_I  in  1  50 MHz clock.
- resetn  in  1  reset, asynchronous, active-low; clock CLOCK_50_I.
- Start  in  1  single-cycle request; sampled only in S_TXI_IDLE.
- Base_address  in  18  first SRAM word address; latched on Start.
- Word_count  in  18  number of 16-bit words to send; latched on Start.
- SRAM_read_data  in  16  read data from SRAM controller.
- SRAM_address  out  18  registered read address.
- SRAM_we_n  out  1  constant 1; this block never writes.
- UART_TX_O  out  1  serial output; idles high.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: SRAM_address=0, SRAM_we_n=1, UART_TX_O=1, Busy=0, Done=0, state S_TXI_IDLE, all counters 0. Reset mid-frame forces UART_TX_O high asynchronously and abandons the transfer; no Done is generated.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT = 4340 cycles.
- S_TXI_IDLE:
  - Start=1 and Word_count=0: Done=1 next cycle, Busy stays 0, no SRAM or UART activity.
  - Start=1 and Word_count>0: latch the count, SRAM_address<=Base_address, Busy<=1, go to S_TXI_FETCH.
- S_TXI_FETCH: wait SRAM_READ_LATENCY+1 cycles after the address edge, then capture SRAM_read_data into the word buffer. Go to S_TXI_SEND_HI; the start bit is driven from the next cycle.
- S_TXI_SEND_HI: shift out buffer[15:8]. Go to S_TXI_SEND_LO on the final cycle of its stop bit.
- S_TXI_SEND_LO: shift out buffer[7:0].
  - In the first cycle of this state, if words remain: SRAM_address<=SRAM_address+1, and prefetch into a second register after the same latency.
  - At the end of the stop bit: if the remaining count is nonzero, load the prefetched word and go to S_TXI_SEND_HI with no idle gap (the next start bit begins the following cycle). Otherwise go to S_TXI_DONE.
- S_TXI_DONE: Done=1 for one cycle, Busy<=0, UART_TX_O=1, return to S_TXI_IDLE.
- Address arithmetic is 18-bit modulo; 0x3FFFF+1 wraps to 0x00000.
- The remaining-word counter decrements once per fully sent word.
- Start while Busy is ignored, including when Start arrives in the same cycle as Done.
- Base_address and Word_count changes after acceptance have no effect.
- Bit counter and baud counter reload at every bit boundary. There is no cumulative drift: frame k starts at exactly k*4340 cycles after the first start bit.

Optional Feature:
- Macro TXI_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit. The frame becomes 11 bits = 4774 cycles; all gapless and timing rules scale accordingly.
- Undefined: plain 8N1 as above, no parity logic synthesized.

Test Plan:
- SRAM[146944]=16'h4A3C; Start with Base=146944, Word_count=1:
  - SRAM_address=146944 one cycle after Start.
  - UART_TX_O sequence: 0,0,1,0,1,0,0,1,0,1 (byte 0x4A), then 0,0,0,1,1,1,1,0,0,1 (byte 0x3C), each bit 434 cycles.
  - Done pulses once, 8680 cycles after the first start bit begins.
- SRAM[0]=16'h1234, SRAM[1]=16'hABCD; Word_count=2:
  - Bytes 12,34,AB,CD are sent back-to-back with no idle cycle between frames.
  - Total 17360 cycles from first start bit to Done; SRAM_we_n=1 throughout.
- Word_count=0: Done=1 the cycle after Start; Busy never asserts; UART_TX_O stays 1.
- Base=0x3FFFF, Word_count=2: addresses 0x3FFFF then 0x00000 are read. A second Start pulse mid-transfer is ignored: same byte stream, only one Done.
- resetn dropped during data bit 3 of the first frame: UART_TX_O=1 and Busy=0 immediately. After release, the block is idle and accepts a new Start normally.
- With TXI_PARITY_EN, word 16'h4A3C: parity bits are 1 (0x4A has three ones) and 0 (0x3C has four ones); each frame lasts 4774 cycles.
